// File: rtl/addsub_pkg.sv
// Shared types and constants for consumers of the 4-bit adder_subtractor.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Bit positions inside the {V,N,Z,C} flag nibble
    localparam logic [1:0] FLG_C = 2'd0;
    localparam logic [1:0] FLG_Z = 2'd1;
    localparam logic [1:0] FLG_N = 2'd2;
    localparam logic [1:0] FLG_V = 2'd3;

    typedef struct packed {
        logic [3:0] flags;
        logic [3:0] sum;
    } addsub_entry_t;

endpackage

// File: rtl/addsub_flag_gen.sv
// Combinational ALU status flags for one adder_subtractor result.
module addsub_flag_gen
    import addsub_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       mode,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic [3:0] flags_c
);

    always_comb begin
        flags_c        = 4'd0;
        flags_c[FLG_C] = cout;
        flags_c[FLG_Z] = (sum == 4'd0);
        flags_c[FLG_N] = sum[3];
        // Subtract overflows when operand signs differ, add when they match
        if (mode == MODE_SUB) begin
            flags_c[FLG_V] = (a[3] != b[3]) && (sum[3] != a[3]);
        end else begin
            flags_c[FLG_V] = (a[3] == b[3]) && (sum[3] != a[3]);
        end
    end

endmodule

// File: rtl/addsub_result_fifo.sv
// Buffers adder_subtractor results with derived flags; drains over valid/ready
// and keeps a saturating count of signed-overflow results.
module addsub_result_fifo
    import addsub_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic                     in_mode,
    input  logic [3:0]               in_sum,
    input  logic                     in_cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_sum,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         ovf_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [3:0]        flags_c;
    addsub_entry_t     new_entry;
    addsub_entry_t     mem [DEPTH];
    addsub_entry_t     head;
    addsub_entry_t     head_n;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr_n;
    logic [LVL_W-1:0]  level_n;
    logic              push;
    logic              pop;

    addsub_flag_gen u_flag_gen (
        .a       (in_a),
        .b       (in_b),
        .mode    (in_mode),
        .sum     (in_sum),
        .cout    (in_cout),
        .flags_c (flags_c)
    );

    // Next-state for pointers, occupancy and the registered head entry
    always_comb begin
        new_entry = '{flags: flags_c, sum: in_sum};
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        level_n   = level;
        head_n    = head;

        if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);

        case ({push, pop})
            2'b10:   level_n = level + LVL_W'(1);
            2'b01:   level_n = level - LVL_W'(1);
            default: level_n = level;
        endcase

        // The new entry is the head only when it lands in the slot being exposed;
        // an empty FIFO keeps showing the last head.
        if (level_n != LVL_W'(0)) begin
            if (push && (wr_ptr == rd_ptr_n)) begin
                head_n = new_entry;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            head      <= '0;
            ovf_count <= '0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            level     <= level_n;
            in_ready  <= (level_n != LVL_W'(DEPTH));
            out_valid <= (level_n != LVL_W'(0));
            head      <= head_n;
            if (push && flags_c[FLG_V] && (ovf_count != '1)) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end
    end

    // Storage array carries no reset; only pointer-covered slots are ever read
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    assign out_sum   = head.sum;
    assign out_flags = head.flags;

endmodule

// File: tb/tb_addsub_result_fifo.sv
// Scoreboard bench for addsub_result_fifo: driver queues expected entries,
// monitor compares the head and occupancy every cycle.
module tb_addsub_result_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_mode;
    logic [3:0] in_sum;
    logic       in_cout;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic [3:0] out_flags;
    logic [2:0] level;
    logic [7:0] ovf_count;

    addsub_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_flags (out_flags),
        .level     (level),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    logic [7:0] last_head = 8'h00;
    int         ovf_exp   = 0;
    bit         armed     = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // What the upstream adder_subtractor would produce: {cout, sum}
    function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic m);
        int u;
        u = m ? (int'(a) + (15 - int'(b)) + 1) : (int'(a) + int'(b));
        return 5'(u);
    endfunction

    // Expected {V,N,Z,C,sum} from signed-range arithmetic
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic m);
        int sa, sb_, r;
        logic [4:0] res;
        logic v, n, z, c;
        sa  = (a >= 8) ? int'(a) - 16 : int'(a);
        sb_ = (b >= 8) ? int'(b) - 16 : int'(b);
        r   = m ? sa - sb_ : sa + sb_;
        res = alu(a, b, m);
        v   = (r > 7) || (r < -8);
        n   = res[3];
        z   = (res[3:0] == 4'd0);
        c   = res[4];
        return {v, n, z, c, res[3:0]};
    endfunction

    // One clock of stimulus; the scoreboard learns of an accepted push after the edge
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic m, input logic ordy, input logic r);
        logic       acc;
        logic [7:0] e;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_mode   = m;
        {in_cout, in_sum} = alu(a, b, m);
        out_ready = ordy;
        #1;
        acc = v && (in_ready === 1'b1) && !r;
        e   = model(a, b, m);
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            ovf_exp   = 0;
            last_head = 8'h00;
            armed     = 1'b1;
        end else if (acc) begin
            sb.push_back(e);
            if (e[7] && ovf_exp != 255) ovf_exp++;
        end
    endtask

    // Monitor: compare state against the scoreboard, then retire a popped head
    initial begin
        logic [7:0] exp_head;
        forever begin
            @(negedge clk);
            #2;
            if (armed) begin
                check("level", int'(level), sb.size());
                check("in_ready", int'(in_ready), int'(sb.size() != 4));
                check("out_valid", int'(out_valid), int'(sb.size() != 0));
                check("ovf_count", int'(ovf_count), ovf_exp);
                exp_head = (sb.size() != 0) ? sb[0] : last_head;
                check("out_sum", int'(out_sum), int'(exp_head[3:0]));
                check("out_flags", int'(out_flags), int'(exp_head[7:4]));
                if (!rst && out_valid === 1'b1 && out_ready && sb.size() != 0) begin
                    last_head = sb.pop_front();
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
        in_sum = '0; in_cout = 1'b0; out_ready = 1'b0;

        step(0, 4'h0, 4'h0, 0, 0, 1);
        check("rst_level", int'(level), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_sum", int'(out_sum), 0);

        // Simple add, then an overflowing add
        step(1, 4'b0001, 4'b0110, 0, 0, 0);
        check("add1_sum", int'(out_sum), 4'b0111);
        check("add1_flags", int'(out_flags), 4'b0000);
        check("add1_level", int'(level), 1);
        step(1, 4'b0101, 4'b0110, 0, 0, 0);
        check("add2_ovf", int'(ovf_count), 1);
        step(0, 4'h0, 4'h0, 0, 1, 0);
        step(0, 4'h0, 4'h0, 0, 1, 0);
        check("drained_hold", int'(out_flags), 4'b1100);

        // Four subtracts fill the FIFO; a fifth is held off
        step(1, 4'b1001, 4'b0010, 1, 0, 0);
        step(1, 4'b1101, 4'b1110, 1, 0, 0);
        step(1, 4'b0011, 4'b0011, 1, 0, 0);
        step(1, 4'b0100, 4'b1000, 1, 0, 0);
        check("full_level", int'(level), 4);
        check("full_in_ready", int'(in_ready), 0);
        check("full_head_flags", int'(out_flags), 4'b1001);
        step(1, 4'b0010, 4'b0001, 1, 0, 0);
        check("held_level", int'(level), 4);
        step(1, 4'b0010, 4'b0001, 1, 1, 0);
        check("full_pop_level", int'(level), 3);
        step(1, 4'b0010, 4'b0001, 1, 0, 0);
        check("refill_level", int'(level), 4);

        // Down to two, then push and pop together
        step(0, 4'h0, 4'h0, 0, 1, 0);
        step(0, 4'h0, 4'h0, 0, 1, 0);
        step(1, 4'b0111, 4'b0001, 0, 1, 0);
        check("pushpop_level", int'(level), 2);
        step(0, 4'h0, 4'h0, 0, 0, 0);

        // Reset mid-stream with level 3 and two overflows recorded
        step(0, 4'h0, 4'h0, 0, 1, 1);
        step(1, 4'b0111, 4'b0111, 0, 0, 0);
        step(1, 4'b1000, 4'b0001, 1, 0, 0);
        step(1, 4'b0001, 4'b0001, 0, 0, 0);
        check("pre_rst_level", int'(level), 3);
        check("pre_rst_ovf", int'(ovf_count), 2);
        step(1, 4'b0111, 4'b0111, 0, 1, 1);
        check("post_rst_level", int'(level), 0);
        check("post_rst_valid", int'(out_valid), 0);
        check("post_rst_ovf", int'(ovf_count), 0);
        check("post_rst_ready", int'(in_ready), 1);

        // Counter saturation
        for (int i = 0; i < 300; i++) step(1, 4'b0111, 4'b0111, 0, 1, 0);
        check("ovf_saturated", int'(ovf_count), 255);
        step(0, 4'h0, 4'h0, 0, 1, 0);
        step(0, 4'h0, 4'h0, 0, 1, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'b0);
        end
        for (int i = 0; i < 6; i++) step(0, 4'h0, 4'h0, 0, 1, 0);
        check("final_level", int'(level), 0);

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
